// File: rtl/fmps_write_link.sv
// FMPS ring link transmitter: merges the local FA-strobe packet with upstream
// traffic, drops self-originated packets, drives an AXI-Stream towards Aurora TX.
module fmps_write_link #(
  parameter int unsigned INDEX_WIDTH = 5,
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [15:0] MAGIC       = 16'hA5C3
) (
  input  logic                   auClk,
  input  logic                   auResetN,
  input  logic                   auFAstrobe,
  input  logic                   inhibit,
  input  logic [INDEX_WIDTH-1:0] localIndex,
  input  logic                   localEnabled,
  input  logic [31:0]            localData,
  input  logic                   upTVALID,
  input  logic                   upTLAST,
  input  logic [31:0]            upTDATA,
  output logic                   upTREADY,
  output logic                   TVALID,
  output logic                   TLAST,
  output logic [31:0]            TDATA,
  input  logic                   TREADY,
  output logic                   localSentStrobe,
  output logic                   loopDropStrobe,
  output logic                   overrunStrobe
);
  localparam int unsigned      DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOCAL, FWD} state_t;

  state_t                 state_q, state_d;
  logic                   pend_q, pend_d;
  logic [INDEX_WIDTH-1:0] snap_idx_q, snap_idx_d;
  logic                   snap_en_q, snap_en_d;
  logic [31:0]            snap_data_q, snap_data_d;
  logic [31:0]            tx_w0_q, tx_w0_d, tx_w1_q, tx_w1_d;
  logic [1:0]             wcnt_q, wcnt_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [31:0]            tdata_q, tdata_d;
  logic                   sent_q, sent_d, drop_q, drop_d, ovr_q, ovr_d;
  logic                   upready_q, upready_d;
  logic                   hdr_q, hdr_d, dropping_q, dropping_d;
  logic [FIFO_AW:0]       wr_q, wr_d, rd_q, rd_d, cnt_d;
  logic [32:0]            mem_q [DEPTH];
  logic                   push, up_hs, hs, is_self, enter_local;

  function automatic logic [31:0] hdr_word(input logic en, input logic [INDEX_WIDTH-1:0] idx);
    return {MAGIC, en, 7'b0, 8'(idx)};
  endfunction

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    snap_idx_d  = snap_idx_q;
    snap_en_d   = snap_en_q;
    snap_data_d = snap_data_q;
    tx_w0_d     = tx_w0_q;
    tx_w1_d     = tx_w1_q;
    wcnt_d      = wcnt_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    sent_d      = 1'b0;
    drop_d      = 1'b0;
    ovr_d       = 1'b0;
    wr_d        = wr_q;
    rd_d        = rd_q;
    push        = 1'b0;
    hdr_d       = hdr_q;
    dropping_d  = dropping_q;
    enter_local = 1'b0;

    up_hs   = upTVALID && upready_q;
    hs      = tvalid_q && TREADY;
    is_self = hdr_q ? (upTDATA[INDEX_WIDTH-1:0] == localIndex) : dropping_q;

    if (up_hs) begin
      hdr_d      = upTLAST;
      dropping_d = is_self;
      if (is_self) begin
        drop_d = hdr_q;
      end else begin
        push = 1'b1;
        wr_d = wr_q + PTR_ONE;
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          enter_local = 1'b1;
          state_d     = LOCAL;
          tx_w0_d     = hdr_word(snap_en_q, snap_idx_q);
          tx_w1_d     = snap_data_q;
          tdata_d     = hdr_word(snap_en_q, snap_idx_q);
          tvalid_d    = 1'b1;
          tlast_d     = 1'b0;
          wcnt_d      = 2'd0;
        end else if (rd_q != wr_q) begin
          state_d             = FWD;
          tvalid_d            = 1'b1;
          {tlast_d, tdata_d}  = mem_q[rd_q[FIFO_AW-1:0]];
        end
      end
      LOCAL: begin
        if (hs) begin
          if (wcnt_q == 2'd0) begin
            tdata_d = tx_w1_q;
            wcnt_d  = 2'd1;
          end else if (wcnt_q == 2'd1) begin
            tdata_d = tx_w0_q ^ tx_w1_q ^ '1;
            tlast_d = 1'b1;
            wcnt_d  = 2'd2;
          end else begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            sent_d   = 1'b1;
          end
        end
      end
      FWD: begin
        // The head word stays in the FIFO until its handshake, so the
        // displayed word counts against the FIFO depth.
        if (hs) rd_d = rd_q + PTR_ONE;
        if (hs && tlast_q) begin
          state_d  = IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tdata_d  = '0;
        end else if (!tvalid_q || hs) begin
          if (rd_d != wr_q) begin
            tvalid_d           = 1'b1;
            {tlast_d, tdata_d} = mem_q[rd_d[FIFO_AW-1:0]];
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (auFAstrobe && !inhibit) begin
      snap_idx_d  = localIndex;
      snap_en_d   = localEnabled;
      snap_data_d = localData;
      pend_d      = 1'b1;
      ovr_d       = pend_q && !enter_local;
    end else if (enter_local) begin
      pend_d = 1'b0;
    end

    cnt_d     = wr_d - rd_d;
    upready_d = (cnt_d != FULL_CNT);
  end

  always_ff @(posedge auClk or negedge auResetN) begin
    if (!auResetN) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      snap_idx_q  <= '0;
      snap_en_q   <= 1'b0;
      snap_data_q <= '0;
      tx_w0_q     <= '0;
      tx_w1_q     <= '0;
      wcnt_q      <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      sent_q      <= 1'b0;
      drop_q      <= 1'b0;
      ovr_q       <= 1'b0;
      upready_q   <= 1'b0;
      hdr_q       <= 1'b1;
      dropping_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      snap_idx_q  <= snap_idx_d;
      snap_en_q   <= snap_en_d;
      snap_data_q <= snap_data_d;
      tx_w0_q     <= tx_w0_d;
      tx_w1_q     <= tx_w1_d;
      wcnt_q      <= wcnt_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      sent_q      <= sent_d;
      drop_q      <= drop_d;
      ovr_q       <= ovr_d;
      upready_q   <= upready_d;
      hdr_q       <= hdr_d;
      dropping_q  <= dropping_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
    end
  end

  always_ff @(posedge auClk) begin
    if (push) mem_q[wr_q[FIFO_AW-1:0]] <= {upTLAST, upTDATA};
  end

  assign upTREADY        = upready_q;
  assign TVALID          = tvalid_q;
  assign TLAST           = tlast_q;
  assign TDATA           = tdata_q;
  assign localSentStrobe = sent_q;
  assign loopDropStrobe  = drop_q;
  assign overrunStrobe   = ovr_q;
endmodule

// File: tb/tb_fmps_write_link.sv
// Bench for fmps_write_link: randomized packets checked against a packet-level
// model of the ring link (local packet formula plus self-index filtering).
module tb_fmps_write_link;
  localparam int unsigned IW = 5;
  localparam int unsigned AW = 4;
  localparam logic [15:0] MG = 16'hA5C3;

  typedef logic [32:0] wq_t[$];

  logic          auClk = 1'b0, auResetN = 1'b1, auFAstrobe = 1'b0, inhibit = 1'b0;
  logic [IW-1:0] localIndex = 5'd3;
  logic          localEnabled = 1'b1;
  logic [31:0]   localData = '0;
  logic          upTVALID = 1'b0, upTLAST = 1'b0;
  logic [31:0]   upTDATA = '0;
  logic          upTREADY, TVALID, TLAST;
  logic [31:0]   TDATA;
  logic          TREADY = 1'b1;
  logic          localSentStrobe, loopDropStrobe, overrunStrobe;

  int checks = 0, errors = 0;
  int cyc = 0, n_sent = 0, n_drop = 0, n_ovr = 0, n_upacc = 0;
  logic [32:0] out_q[$];
  int          out_cyc[$];
  logic [32:0] exp_q[$];

  fmps_write_link #(.INDEX_WIDTH(IW), .FIFO_AW(AW), .MAGIC(MG)) dut (
    .auClk(auClk), .auResetN(auResetN), .auFAstrobe(auFAstrobe), .inhibit(inhibit),
    .localIndex(localIndex), .localEnabled(localEnabled), .localData(localData),
    .upTVALID(upTVALID), .upTLAST(upTLAST), .upTDATA(upTDATA), .upTREADY(upTREADY),
    .TVALID(TVALID), .TLAST(TLAST), .TDATA(TDATA), .TREADY(TREADY),
    .localSentStrobe(localSentStrobe), .loopDropStrobe(loopDropStrobe),
    .overrunStrobe(overrunStrobe)
  );

  always #5 auClk = ~auClk;
  always @(posedge auClk) cyc++;

  always @(negedge auClk) begin
    if (TVALID && TREADY) begin
      out_q.push_back({TLAST, TDATA});
      out_cyc.push_back(cyc);
    end
    if (upTVALID && upTREADY) n_upacc++;
    if (localSentStrobe) n_sent++;
    if (loopDropStrobe) n_drop++;
    if (overrunStrobe) n_ovr++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // Reference packet words: header, data, inverted xor checksum with TLAST.
  function automatic logic [32:0] lw(input logic [IW-1:0] idx, input logic en,
                                     input logic [31:0] d, input int k);
    logic [31:0] w0;
    w0 = {MG, en, 7'd0, 3'd0, idx};
    if (k == 0) return {1'b0, w0};
    if (k == 1) return {1'b0, d};
    return {1'b1, w0 ^ d ^ 32'hFFFFFFFF};
  endfunction

  task automatic expect_local(input logic [IW-1:0] idx, input logic en, input logic [31:0] d);
    for (int k = 0; k < 3; k++) exp_q.push_back(lw(idx, en, d, k));
  endtask

  function automatic wq_t mk_pkt(input logic [IW-1:0] idx, input int len);
    wq_t q;
    logic [31:0] w;
    for (int k = 0; k < len; k++) begin
      w = $urandom();
      if (k == 0) w[IW-1:0] = idx;
      q.push_back({(k == len - 1), w});
    end
    return q;
  endfunction

  task automatic tick();
    @(posedge auClk);
    #1;
  endtask

  task automatic strobe_pulse();
    auFAstrobe = 1'b1;
    tick();
    auFAstrobe = 1'b0;
  endtask

  task automatic send_up(input wq_t pkt);
    foreach (pkt[i]) begin
      int g;
      g = 0;
      {upTLAST, upTDATA} = pkt[i];
      upTVALID = 1'b1;
      @(negedge auClk);
      while (!upTREADY && g < 300) begin
        @(negedge auClk);
        g++;
      end
      if (!upTREADY) begin
        errors++;
        $display("FAIL up_accept got timeout want upTREADY word %0d", i);
      end
      @(posedge auClk);
      #1;
    end
    upTVALID = 1'b0;
  endtask

  task automatic wait_out(input int target, input bit rnd);
    int g;
    g = 0;
    while (out_q.size() < target && g < 400) begin
      if (rnd) TREADY = ($urandom_range(0, 3) != 0);
      tick();
      g++;
    end
    TREADY = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    #2 auResetN = 1'b0;
    #1;
    checks++;
    if ({TVALID, TLAST, upTREADY, localSentStrobe, loopDropStrobe, overrunStrobe} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {TVALID, TLAST, upTREADY, localSentStrobe, loopDropStrobe, overrunStrobe});
    end
    checks++;
    if (TDATA !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", TDATA); end
    repeat (3) tick();
    auResetN = 1'b1;
    tick();
    checks++;
    if (upTREADY !== 1'b1 || TVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", upTREADY, TVALID);
    end
  endtask

  task automatic test_local();
    int base, s0;
    logic [31:0] w0, w1;
    s0 = n_sent;
    localIndex = 5'd3; localEnabled = 1'b1; localData = 32'h12345678; TREADY = 1'b1;
    w0 = 32'hA5C38003; w1 = 32'h12345678;
    strobe_pulse();
    checks++;
    if (TVALID !== 1'b0) begin errors++; $display("FAIL local_lat1 got %b want 0", TVALID); end
    tick();
    checks++;
    if ({TVALID, TLAST, TDATA} !== {2'b10, w0}) begin
      errors++; $display("FAIL local_w0 got %b%b %h want 10 %h", TVALID, TLAST, TDATA, w0);
    end
    tick();
    checks++;
    if ({TVALID, TLAST, TDATA} !== {2'b10, w1}) begin
      errors++; $display("FAIL local_w1 got %b%b %h want 10 %h", TVALID, TLAST, TDATA, w1);
    end
    tick();
    checks++;
    if ({TVALID, TLAST, TDATA} !== {2'b11, w0 ^ w1 ^ 32'hFFFFFFFF}) begin
      errors++; $display("FAIL local_w2 got %b%b %h want 11 %h", TVALID, TLAST, TDATA,
                         w0 ^ w1 ^ 32'hFFFFFFFF);
    end
    tick();
    checks++;
    if (TVALID !== 1'b0 || localSentStrobe !== 1'b1) begin
      errors++; $display("FAIL local_end got vld=%b sent=%b want vld=0 sent=1", TVALID, localSentStrobe);
    end
    tick();
    checks++;
    if (n_sent - s0 !== 1) begin errors++; $display("FAIL local_sent_count got %0d want 1", n_sent - s0); end

    exp_q.delete();
    base = out_q.size();
    s0 = n_sent;
    for (int i = 0; i < 4; i++) begin
      localIndex   = IW'($urandom_range(0, 31));
      localEnabled = 1'($urandom_range(0, 1));
      localData    = $urandom();
      expect_local(localIndex, localEnabled, localData);
      strobe_pulse();
      wait_out(base + 3 * (i + 1), 1'b1);
    end
    localIndex = 5'd3;
    checks++;
    if (out_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL rand_local_count got %0d want %0d", out_q.size() - base, exp_q.size());
    end
    foreach (exp_q[i]) if (base + i < out_q.size()) begin
      checks++;
      if (out_q[base + i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_local_word[%0d] got %h want %h", i, out_q[base + i], exp_q[i]);
      end
    end
    checks++;
    if (n_sent - s0 !== 4) begin errors++; $display("FAIL rand_local_sent got %0d want 4", n_sent - s0); end
  endtask

  task automatic test_self_drop();
    int base, d0, ndrop;
    wq_t p;
    logic [IW-1:0] idx;
    localIndex = 5'd3; TREADY = 1'b1;
    exp_q.delete();
    base = out_q.size();
    d0 = n_drop;
    ndrop = 0;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) idx = 5'd3;
      else if (n == 1) idx = 5'd7;
      else idx = ($urandom_range(0, 2) == 0) ? 5'd3 : IW'($urandom_range(0, 31));
      p = mk_pkt(idx, (n < 2) ? 3 : int'($urandom_range(1, 5)));
      if (idx == localIndex) ndrop++;
      else foreach (p[j]) exp_q.push_back(p[j]);
      send_up(p);
    end
    wait_out(base + exp_q.size(), 1'b0);
    checks++;
    if (n_drop - d0 !== ndrop) begin errors++; $display("FAIL drop_count got %0d want %0d", n_drop - d0, ndrop); end
    checks++;
    if (out_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL drop_fwd_count got %0d want %0d", out_q.size() - base, exp_q.size());
    end
    foreach (exp_q[i]) if (base + i < out_q.size()) begin
      checks++;
      if (out_q[base + i] !== exp_q[i]) begin
        errors++; $display("FAIL drop_fwd_word[%0d] got %h want %h", i, out_q[base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_priority();
    int base;
    wq_t p;
    localIndex = 5'd3; localEnabled = 1'b0; localData = $urandom(); TREADY = 1'b1;
    exp_q.delete();
    base = out_q.size();
    p = mk_pkt(5'd9, 3);
    foreach (p[j]) exp_q.push_back(p[j]);
    expect_local(localIndex, localEnabled, localData);
    fork
      send_up(p);
      begin
        int g;
        g = 0;
        while (g < 100) begin
          @(negedge auClk);
          if (TVALID && TDATA === p[0][31:0]) break;
          g++;
        end
        checks++;
        if (g >= 100) begin errors++; $display("FAIL prio_fwd_start got timeout want header"); end
        auFAstrobe = 1'b1;
        @(posedge auClk);
        #1;
        auFAstrobe = 1'b0;
      end
    join
    wait_out(base + 6, 1'b0);
    checks++;
    if (out_q.size() - base !== 6) begin
      errors++; $display("FAIL prio_count got %0d want 6", out_q.size() - base);
    end
    foreach (exp_q[i]) if (base + i < out_q.size()) begin
      checks++;
      if (out_q[base + i] !== exp_q[i]) begin
        errors++; $display("FAIL prio_word[%0d] got %h want %h", i, out_q[base + i], exp_q[i]);
      end
    end
    if (out_q.size() >= base + 4) begin
      checks++;
      if (out_cyc[base + 3] - out_cyc[base + 2] !== 2) begin
        errors++; $display("FAIL prio_gap got %0d want 2", out_cyc[base + 3] - out_cyc[base + 2]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base, a0, rem, len;
    wq_t p, stream;
    logic [IW-1:0] idx;
    localIndex = 5'd3;
    TREADY = 1'b0;
    rem = 20;
    while (rem > 0) begin
      len = $urandom_range(1, 5);
      if (len > rem) len = rem;
      do idx = IW'($urandom_range(0, 31)); while (idx == localIndex);
      p = mk_pkt(idx, len);
      foreach (p[j]) stream.push_back(p[j]);
      rem -= len;
    end
    base = out_q.size();
    a0 = n_upacc;
    fork
      send_up(stream);
      begin
        repeat (40) tick();
        checks++;
        if (n_upacc - a0 !== 16) begin errors++; $display("FAIL bp_accepted got %0d want 16", n_upacc - a0); end
        checks++;
        if (upTREADY !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", upTREADY); end
        checks++;
        if ({TVALID, TLAST, TDATA} !== {1'b1, stream[0]}) begin
          errors++; $display("FAIL bp_hold got %b %b %h want 1 %h", TVALID, TLAST, TDATA, stream[0]);
        end
        TREADY = 1'b1;
      end
    join
    wait_out(base + 20, 1'b0);
    checks++;
    if (out_q.size() - base !== 20) begin
      errors++; $display("FAIL bp_count got %0d want 20", out_q.size() - base);
    end
    foreach (stream[i]) if (base + i < out_q.size()) begin
      checks++;
      if (out_q[base + i] !== stream[i]) begin
        errors++; $display("FAIL bp_word[%0d] got %h want %h", i, out_q[base + i], stream[i]);
      end
    end
    checks++;
    if (upTREADY !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", upTREADY); end
  endtask

  task automatic test_overrun_inhibit();
    int base, o0, s0;
    wq_t p;
    localIndex = 5'd3;
    TREADY = 1'b0;
    exp_q.delete();
    base = out_q.size();
    o0 = n_ovr;
    s0 = n_sent;
    p = mk_pkt(5'd12, 3);
    foreach (p[j]) exp_q.push_back(p[j]);
    send_up(p);
    localEnabled = 1'b1; localData = $urandom();
    strobe_pulse();
    repeat (2) tick();
    localEnabled = 1'b0; localData = $urandom();
    expect_local(localIndex, localEnabled, localData);
    strobe_pulse();
    repeat (3) tick();
    checks++;
    if (n_ovr - o0 !== 1) begin errors++; $display("FAIL ovr_count got %0d want 1", n_ovr - o0); end
    TREADY = 1'b1;
    wait_out(base + 6, 1'b0);
    checks++;
    if (out_q.size() - base !== 6) begin
      errors++; $display("FAIL ovr_pkt_count got %0d want 6", out_q.size() - base);
    end
    foreach (exp_q[i]) if (base + i < out_q.size()) begin
      checks++;
      if (out_q[base + i] !== exp_q[i]) begin
        errors++; $display("FAIL ovr_word[%0d] got %h want %h", i, out_q[base + i], exp_q[i]);
      end
    end
    inhibit = 1'b1;
    localData = $urandom();
    strobe_pulse();
    inhibit = 1'b0;
    repeat (20) tick();
    checks++;
    if (out_q.size() - base !== 6) begin
      errors++; $display("FAIL inhibit_words got %0d want 6", out_q.size() - base);
    end
    checks++;
    if (n_sent - s0 !== 1 || n_ovr - o0 !== 1) begin
      errors++; $display("FAIL inhibit_strobes got sent=%0d ovr=%0d want sent=1 ovr=1", n_sent - s0, n_ovr - o0);
    end
  endtask

  task automatic test_reset_mid();
    int base, s0;
    logic [31:0] d;
    localIndex = 5'd3; localEnabled = 1'b1;
    d = $urandom();
    localData = d;
    TREADY = 1'b0;
    strobe_pulse();
    repeat (3) tick();
    send_up(mk_pkt(5'd20, 3));
    TREADY = 1'b1;
    tick();
    TREADY = 1'b0;
    checks++;
    if ({TVALID, TLAST, TDATA} !== {2'b10, d}) begin
      errors++; $display("FAIL rmid_w1 got %b%b %h want 10 %h", TVALID, TLAST, TDATA, d);
    end
    auResetN = 1'b0;
    #1;
    checks++;
    if ({TVALID, TLAST, TDATA, upTREADY} !== 35'h0) begin
      errors++; $display("FAIL rmid_async got vld=%b last=%b data=%h rdy=%b want all 0",
                         TVALID, TLAST, TDATA, upTREADY);
    end
    repeat (2) tick();
    auResetN = 1'b1;
    TREADY = 1'b1;
    base = out_q.size();
    s0 = n_sent;
    repeat (12) tick();
    checks++;
    if (out_q.size() !== base) begin
      errors++; $display("FAIL rmid_empty got %0d words want 0", out_q.size() - base);
    end
    exp_q.delete();
    localData = $urandom();
    expect_local(localIndex, localEnabled, localData);
    strobe_pulse();
    wait_out(base + 3, 1'b0);
    checks++;
    if (out_q.size() - base !== 3) begin
      errors++; $display("FAIL rmid_count got %0d want 3", out_q.size() - base);
    end
    foreach (exp_q[i]) if (base + i < out_q.size()) begin
      checks++;
      if (out_q[base + i] !== exp_q[i]) begin
        errors++; $display("FAIL rmid_word[%0d] got %h want %h", i, out_q[base + i], exp_q[i]);
      end
    end
    checks++;
    if (n_sent - s0 !== 1) begin errors++; $display("FAIL rmid_sent got %0d want 1", n_sent - s0); end
  endtask

  initial begin
    test_reset();
    test_local();
    test_self_drop();
    test_priority();
    test_backpressure();
    test_overrun_inhibit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
